// File: rtl/spi_rx_deserializer.sv
// SPI receive deserializer: oversamples sclk/mosi/cs, assembles LSB-first frames into a one-entry
// valid/ready output buffer. Define SPI_RX_TIMEOUT_EN to abort frames whose sclk stalls while cs is low.
module spi_rx_deserializer #(
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              cs,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              done,
    output logic              frame_err,
    output logic              overrun
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        WAIT_CS,
        IDLE,
        RECV
    } state_e;

    if (SYNC_STAGES < 2 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("spi_rx_deserializer: SYNC_STAGES must be >= 2 and TIMEOUT_CYC >= 1");
    end

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q, primed_q;
    logic                   sclk_prev_q;
    logic                   sclk_s, mosi_s, cs_s, primed, rise;

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              done_q, done_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic              last_bit, timeout_hit;

    // NOTE: sequential state uses non-blocking assignments only; all next-state math lives in always_comb.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
            primed_q    <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            primed_q    <= {primed_q[SYNC_STAGES-2:0], 1'b1};
            sclk_prev_q <= sclk_s;
        end
    end

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_prev_q;
    // The cs preset must not let WAIT_CS exit until the real pin value has flushed through the synchronizer.
    assign primed = primed_q[SYNC_STAGES-1];

    assign last_bit = (bitcnt_q == CNT_W'(DATA_W - 1));

`ifdef SPI_RX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d = '0;
        if (state_q == RECV && !cs_s && !rise) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    assign timeout_hit = (state_q == RECV) && !cs_s && !rise && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_CS;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; cs_s takes priority over a coincident rise event.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_CS: if (primed && cs_s) state_d = IDLE;
            IDLE:    if (!cs_s) state_d = RECV;
            RECV: begin
                if (cs_s)                  state_d = IDLE;
                else if (rise && last_bit) state_d = WAIT_CS;
                else if (timeout_hit)      state_d = WAIT_CS;
            end
            default: state_d = WAIT_CS;
        endcase
    end

    // Output and datapath logic
    // NOTE: every variable gets a default at the top of the block so no path infers a latch.
    always_comb begin
        shift_d      = shift_q;
        bitcnt_d     = bitcnt_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        done_d       = 1'b0;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;

        if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (!cs_s) begin
                    shift_d  = '0;
                    bitcnt_d = '0;
                end
            end
            RECV: begin
                if (cs_s) begin
                    frame_err_d = 1'b1;
                end else if (rise) begin
                    shift_d[bitcnt_q] = mosi_s;
                    bitcnt_d          = bitcnt_q + CNT_W'(1);
                    if (last_bit) begin
                        if (!dout_valid_q || dout_ready) begin
                            dout_d       = shift_d;
                            dout_valid_d = 1'b1;
                            done_d       = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end else if (timeout_hit) begin
                    frame_err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q      <= '0;
            bitcnt_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            done_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            bitcnt_q     <= bitcnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            done_q       <= done_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign done       = done_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_spi_rx_deserializer.sv
// Scoreboard bench for spi_rx_deserializer: stimulus queues expected done/frame_err/overrun events,
// a negedge monitor pops and compares them as the DUT raises its pulses.
module tb_spi_rx_deserializer;

    localparam int DATA_W = 12;
    localparam int SYNC   = 2;
    localparam int HALF   = 11;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sclk = 1'b0;
    logic              mosi = 1'b0;
    logic              cs = 1'b1;
    logic              dout_ready = 1'b0;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              done;
    logic              frame_err;
    logic              overrun;

    spi_rx_deserializer #(
        .DATA_W     (DATA_W),
        .SYNC_STAGES(SYNC),
        .TIMEOUT_CYC(64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .mosi      (mosi),
        .cs        (cs),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .done      (done),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_DONE, EV_ERR, EV_OVR} ev_kind_e;
    typedef struct {
        ev_kind_e          kind;
        logic [DATA_W-1:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input ev_kind_e kind, input logic [DATA_W-1:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic expect_event(input ev_kind_e kind, input string name);
        ev_t e;
        if (exp_q.size() == 0) begin
            check({"unexpected_", name}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({name, "_kind"}, 32'(kind), 32'(e.kind));
            if (kind != EV_ERR) check({name, "_dout"}, 32'(dout), 32'(e.data));
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (done)      expect_event(EV_DONE, "done");
            if (frame_err) expect_event(EV_ERR, "frame_err");
            if (overrun)   expect_event(EV_OVR, "overrun");
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves sclk high after the last bit so the caller can watch the completion.
    task automatic send_bits(input logic [DATA_W-1:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            mosi = w[i];
            sclk = 1'b0;
            tick(HALF);
            sclk = 1'b1;
            if (i != n - 1) tick(HALF);
        end
    endtask

    task automatic finish_frame();
        tick(HALF);
        sclk = 1'b0;
        tick(HALF);
        cs = 1'b1;
        tick(15);
    endtask

    task automatic full_frame(input logic [DATA_W-1:0] w);
        cs = 1'b0;
        tick(HALF);
        send_bits(w, DATA_W);
        finish_frame();
    endtask

    task automatic wait_done(output bit hit);
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            @(negedge clk);
            if (done) hit = 1'b1;
        end
    endtask

    initial begin
        bit hit;
        logic [DATA_W-1:0] w;
        int cnt;

        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_valid", 32'(dout_valid), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        tick(5);

        // A5C with consumer ready: valid lasts one cycle
        dout_ready = 1'b1;
        push(EV_DONE, 12'hA5C);
        cs = 1'b0;
        tick(HALF);
        send_bits(12'hA5C, DATA_W);
        wait_done(hit);
        check("a5c_done_seen", 32'(hit), 32'h1);
        check("a5c_valid_at_done", 32'(dout_valid), 32'h1);
        @(negedge clk);
        check("a5c_valid_one_cycle", 32'(dout_valid), 32'h0);
        finish_frame();

        // 3F1 with consumer stalled, then released
        dout_ready = 1'b0;
        push(EV_DONE, 12'h3F1);
        cs = 1'b0;
        tick(HALF);
        send_bits(12'h3F1, DATA_W);
        wait_done(hit);
        check("3f1_done_seen", 32'(hit), 32'h1);
        finish_frame();
        check("3f1_valid_held", 32'(dout_valid), 32'h1);
        check("3f1_dout_held", 32'(dout), 32'h3F1);
        dout_ready = 1'b1;
        @(negedge clk);
        check("3f1_valid_before_edge", 32'(dout_valid), 32'h1);
        @(negedge clk);
        check("3f1_valid_dropped", 32'(dout_valid), 32'h0);
        tick(5);

        // Short frame: cs raised after 5 bits
        push(EV_ERR, '0);
        cs = 1'b0;
        tick(HALF);
        send_bits(12'hFFF, 5);
        finish_frame();
        check("short_valid_low", 32'(dout_valid), 32'h0);
        push(EV_DONE, 12'h001);
        full_frame(12'h001);
        check("after_short_dout", 32'(dout), 32'h001);

        // Back-to-back with consumer stalled: second frame overruns
        dout_ready = 1'b0;
        push(EV_DONE, 12'h123);
        push(EV_OVR, 12'h123);
        full_frame(12'h123);
        full_frame(12'h456);
        check("ovr_dout_kept", 32'(dout), 32'h123);
        check("ovr_valid_kept", 32'(dout_valid), 32'h1);
        dout_ready = 1'b1;
        tick(2);
        check("ovr_valid_drained", 32'(dout_valid), 32'h0);

        // Reset mid-frame: partial frame lost silently
        w = 12'h3C5;
        cs = 1'b0;
        tick(HALF);
        send_bits(w, 6);
        tick(HALF);
        sclk = 1'b0;
        tick(HALF);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(3);
        check("midrst_dout", 32'(dout), 32'h0);
        check("midrst_valid", 32'(dout_valid), 32'h0);
        send_bits(w >> 6, 6);
        finish_frame();
        check("midrst_no_valid", 32'(dout_valid), 32'h0);
        push(EV_DONE, 12'h0AA);
        full_frame(12'h0AA);
        check("midrst_next_dout", 32'(dout), 32'h0AA);

        // sclk stalls after 3 bits with cs low
        cs = 1'b0;
        tick(HALF);
`ifdef SPI_RX_TIMEOUT_EN
        push(EV_ERR, '0);
        send_bits(12'h005, 3);
        cnt = 0;
        while (!frame_err && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("timeout_latency_in_window", 32'(cnt >= 64 && cnt <= 64 + SYNC + 4), 32'h1);
        tick(HALF);
        sclk = 1'b0;
        tick(HALF);
        cs = 1'b1;
        tick(15);
`else
        send_bits(12'h005, 3);
        cnt = 0;
        tick(100);
        check("stall_valid_low", 32'(dout_valid), 32'h0);
        check("stall_queue_idle", 32'(exp_q.size()), 32'h0);
        push(EV_ERR, '0);
        sclk = 1'b0;
        tick(HALF);
        cs = 1'b1;
        tick(15);
`endif

        tick(20);
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
